cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single integer common data bus (cdb_int: 6-bit ROB tag + 32-bit result) between NREQ functional units.
- Each unit owns a 1-entry holding slot. A round-robin arbiter drains one slot per cycle onto a registered CDB output.
- The CDB output feeds the reorder buffer result write port and the reservation-station wakeup logic.
- Tag 0 is the null tag: an idle bus drives all zeros.

Parameters:
- NREQ, 4, number of requesting functional units (2..8)
- TAG_W, 6, ROB tag width
- DATA_W, 32, result data width

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous pipeline flush; discards all pending results
- req_valid  input  NREQ  per-unit result valid
- req_tag  input  NREQ*TAG_W  per-unit ROB tag; unit i uses bits [i*TAG_W +: TAG_W]
- req_data  input  NREQ*DATA_W  per-unit result; unit i uses bits [i*DATA_W +: DATA_W]
- req_ready  output  NREQ  per-unit accept; a transfer occurs when req_valid[i] && req_ready[i] at a rising edge
- cdb_int  output  TAG_W+DATA_W  registered broadcast {tag, data}
- cdb_valid  output  1  registered; high when cdb_int carries a real result
- grant_id  output  $clog2(NREQ)  registered; index of the unit that owns the current cdb_int

Behaviour:
- Reset (reset low, async):
  - slots empty; rr pointer = 0; cdb_int = 0, cdb_valid = 0, grant_id = 0.
  - req_ready = 0 for all units while reset is low.
- Slot i state: full bit, tag, data.
  - req_ready[i] = reset && !flush && (!full[i] || grant[i]), i.e. the slot may be refilled in the same cycle it drains.
  - req_ready may depend on req_valid only through grant.
- Accept:
  - On a transfer, slot i loads {req_tag, req_data} and full[i] = 1.
  - If req_tag == 0, the transfer completes (ready honoured) but the slot is not loaded: the result is dropped.
- Arbitration (combinational on slot full bits):
  - Search starts at pointer p and proceeds p, p+1, ..., wrapping at NREQ-1 -> 0.
  - The first full slot k gets grant[k] = 1; at most one grant per cycle.
- On grant to k:
  - Next edge: cdb_int <= {tag[k], data[k]}, cdb_valid <= 1, grant_id <= k, full[k] cleared (unless refilled in the same cycle), p <= (k+1) mod NREQ.
- No grant: cdb_int <= 0, cdb_valid <= 0, grant_id and p hold.
- Latency: transfer at edge N -> slot full in cycle N+1 -> on cdb_int in cycle N+2 when uncontended.
- The CDB has no backpressure: a broadcast value is valid for exactly one cycle.
- Throughput: 1 result/cycle in total; a lone active unit sustains 1/cycle via same-cycle refill.
- Fairness: any full slot is granted within NREQ cycles.
- Flush (sampled at edge):
  - All full bits cleared; cdb_int <= 0, cdb_valid <= 0; p holds.
  - Transfers in the flush cycle are impossible (ready = 0).
  - A result already on cdb_int during the flush cycle remains visible that cycle only.
- Simultaneous grant and refill of the same slot: the slot ends full with the new data; the old data goes to the CDB.
- Reset asserted mid-operation: all pending results are discarded immediately (async); there is no partial broadcast.

Test Plan:
1. Reset low then high, no requests -> cdb_int = 0, cdb_valid = 0, grant_id = 0, req_ready = 4'b1111 after release; req_ready = 0 while reset is low.
2. Unit 2 sends tag 5, data 0xDEADBEEF at edge N -> cdb_valid = 1 with cdb_int = {6'd5, 32'hDEADBEEF} and grant_id = 2 in cycle N+2 only; 0 in cycle N+3.
3. All 4 units send tags 1..4 in the same cycle, pointer = 0 -> broadcasts in order tags 1, 2, 3, 4 on 4 consecutive cycles. Next, units 0 and 3 send together -> unit 0 first (pointer = 0 after wrap), then unit 3.
4. Unit 1 holds req_valid high for 8 cycles with tags 10..17, others idle -> req_ready[1] stays 1 and tags 10..17 appear back-to-back starting 2 cycles after the first transfer.
5. Units 0 and 1 full, flush pulsed one cycle -> both slots cleared; cdb_valid = 0 on the next cycle; req_ready = 0 during the flush cycle; no tags broadcast afterwards.
6. Unit 3 sends tag 0 with data 0x1234 -> accepted (ready = 1) but cdb_valid stays 0. Separately, reset dropped while 3 slots are full -> outputs are 0 immediately and nothing is broadcast after release.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin share of the integer CDB among NREQ units, each with a 1-entry holding slot.
// Latency: transfer -> slot full next cycle -> on CDB the cycle after; CDB has no backpressure, units see req_ready.
module cdb_arbiter #(
    parameter int NREQ   = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*TAG_W-1:0]     req_tag,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [TAG_W+DATA_W-1:0]   cdb_int,
    output logic                      cdb_valid,
    output logic [$clog2(NREQ)-1:0]   grant_id
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]          r_full;
    logic [TAG_W-1:0]         r_tag  [NREQ];
    logic [DATA_W-1:0]        r_data [NREQ];
    logic [IDW-1:0]           r_ptr;
    logic [TAG_W+DATA_W-1:0]  r_cdb;
    logic                     r_cdb_vld;
    logic [IDW-1:0]           r_gid;

    logic                     w_gnt_any;
    logic [IDW-1:0]           w_gnt_idx;
    logic [NREQ-1:0]          w_grant;
    logic [NREQ-1:0]          w_load;
    logic [IDW-1:0]           w_ptr_nxt;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // First full slot at or after the pointer wins
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int o = 0; o < NREQ; o++) begin
            if (!w_gnt_any && r_full[wrap_add(r_ptr, o)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = wrap_add(r_ptr, o);
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_gnt_any) w_grant[w_gnt_idx] = 1'b1;
    end

    // A draining slot may be refilled in the same cycle
    assign req_ready = {NREQ{reset & ~flush}} & (~r_full | w_grant);

    // Null-tag transfers are accepted but never occupy the slot
    always_comb begin
        w_load = '0;
        for (int i = 0; i < NREQ; i++)
            w_load[i] = req_valid[i] & req_ready[i] & (|req_tag[i*TAG_W +: TAG_W]);
    end

    assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + IDW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full    <= '0;
            r_ptr     <= '0;
            r_cdb     <= '0;
            r_cdb_vld <= 1'b0;
            r_gid     <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_full    <= '0;
            r_cdb     <= '0;
            r_cdb_vld <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_load[i]) begin
                    r_full[i] <= 1'b1;
                    r_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
                    r_data[i] <= req_data[i*DATA_W +: DATA_W];
                end else if (w_grant[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
            if (w_gnt_any) begin
                r_cdb     <= {r_tag[w_gnt_idx], r_data[w_gnt_idx]};
                r_cdb_vld <= 1'b1;
                r_gid     <= w_gnt_idx;
                r_ptr     <= w_ptr_nxt;
            end else begin
                r_cdb     <= '0;
                r_cdb_vld <= 1'b0;
            end
        end
    end

    assign cdb_int   = r_cdb;
    assign cdb_valid = r_cdb_vld;
    assign grant_id  = r_gid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin order, streaming, flush, null tag, async reset.
module tb_cdb_arbiter;
    localparam int NREQ = 4, TAG_W = 6, DATA_W = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     flush;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*TAG_W-1:0]    req_tag;
    logic [NREQ*DATA_W-1:0]   req_data;
    logic [NREQ-1:0]          req_ready;
    logic [TAG_W+DATA_W-1:0]  cdb_int;
    logic                     cdb_valid;
    logic [1:0]               grant_id;

    int n_chk  = 0;
    int n_fail = 0;

    cdb_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_ready(req_ready), .cdb_int(cdb_int), .cdb_valid(cdb_valid),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int u, input int tag, input logic [31:0] dat);
        req_valid[u] = 1'b1;
        req_tag[u*TAG_W +: TAG_W] = TAG_W'(tag);
        req_data[u*DATA_W +: DATA_W] = dat;
    endtask

    task automatic idle;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
    endtask

    task automatic pulse_reset;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
    endtask

    task automatic expect_bcast(input string name, input int tag, input logic [31:0] dat, input int gid);
        check({name, "_vld"}, 64'(cdb_valid), 64'd1);
        check({name, "_int"}, 64'(cdb_int), {26'd0, TAG_W'(tag), dat});
        check({name, "_gid"}, 64'(grant_id), 64'(gid));
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        idle();

        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_vld",   64'(cdb_valid), 64'h0);
        check("rst_int",   64'(cdb_int),   64'h0);
        check("rst_gid",   64'(grant_id),  64'h0);
        reset = 1'b1;
        tick();
        check("rel_ready", 64'(req_ready), 64'hf);
        check("rel_vld",   64'(cdb_valid), 64'h0);

        // 2: single transfer latency
        put(2, 5, 32'hDEADBEEF);
        tick();
        idle();
        check("t2_n1_vld", 64'(cdb_valid), 64'h0);
        tick();
        expect_bcast("t2_n2", 5, 32'hDEADBEEF, 2);
        tick();
        check("t2_n3_vld", 64'(cdb_valid), 64'h0);
        check("t2_n3_int", 64'(cdb_int),   64'h0);

        // 3: round-robin order from pointer 0, then wrap
        pulse_reset();
        for (int u = 0; u < NREQ; u++) put(u, u + 1, 32'h100 + u);
        tick();
        idle();
        for (int u = 0; u < NREQ; u++) begin
            tick();
            expect_bcast($sformatf("t3_rr%0d", u), u + 1, 32'h100 + u, u);
        end
        tick();
        check("t3_gap_vld", 64'(cdb_valid), 64'h0);
        put(0, 7, 32'hA0);
        put(3, 8, 32'hA3);
        tick();
        idle();
        tick();
        expect_bcast("t3_u0", 7, 32'hA0, 0);
        tick();
        expect_bcast("t3_u3", 8, 32'hA3, 3);
        tick();
        check("t3_end_vld", 64'(cdb_valid), 64'h0);

        // 4: lone unit streaming at one per cycle
        for (int i = 0; i < 8; i++) begin
            put(1, 10 + i, 32'h1000 + i);
            #1;
            check($sformatf("t4_rdy%0d", i), 64'(req_ready[1]), 64'd1);
            tick();
            if (i >= 1) expect_bcast($sformatf("t4_b%0d", i - 1), 10 + i - 1, 32'h1000 + i - 1, 1);
        end
        idle();
        tick();
        expect_bcast("t4_b7", 17, 32'h1007, 1);
        tick();
        check("t4_end_vld", 64'(cdb_valid), 64'h0);

        // 5: flush discards pending slots
        put(0, 20, 32'h20);
        put(1, 21, 32'h21);
        tick();
        flush = 1'b1;
        #1;
        check("t5_flush_rdy", 64'(req_ready), 64'h0);
        tick();
        flush = 1'b0;
        idle();
        check("t5_post_vld", 64'(cdb_valid), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t5_quiet%0d", i), 64'(cdb_valid), 64'h0);
        end

        // 6a: null tag accepted but dropped
        put(3, 0, 32'h1234);
        #1;
        check("t6_null_rdy", 64'(req_ready[3]), 64'd1);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_null_vld%0d", i), 64'(cdb_valid), 64'h0);
        end

        // 6b: async reset with three slots pending
        put(0, 30, 32'h30);
        put(1, 31, 32'h31);
        put(2, 32, 32'h32);
        tick();
        idle();
        tick();
        check("t6_pre_vld", 64'(cdb_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_ar_vld", 64'(cdb_valid), 64'h0);
        check("t6_ar_int", 64'(cdb_int),   64'h0);
        check("t6_ar_gid", 64'(grant_id),  64'h0);
        check("t6_ar_rdy", 64'(req_ready), 64'h0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t6_after%0d", i), 64'(cdb_valid), 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
